// File: rtl/ro_path_sequencer.sv
// ro_path_sequencer: launches transitions into one of NUM_PATHS inverter-chain
// delay paths, samples the selected output settle+1 cycles after launch, and
// counts trials and mismatches against the expected settled level.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; counts and path_in hold
// S_LAUNCH  | toggle path_in[sel] at the exiting edge, load wait counter
// S_WAIT    | settle cycles of down-counting before capture
// S_CAPTURE | raw single-flop capture of path_out[sel] at the exiting edge
// S_CHECK   | compare capture with launched level, bump counters
// S_DONE    | one-cycle completion pulse
module ro_path_sequencer #(
  parameter int NUM_PATHS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 16,
  parameter int WAIT_W    = 4,
  parameter bit INVERT    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SEL_W-1:0]     path_sel,
  input  logic [CNT_W-1:0]     num_trials,
  input  logic [WAIT_W-1:0]    settle_cycles,
  output logic [NUM_PATHS-1:0] path_in,
  input  logic [NUM_PATHS-1:0] path_out,
  output logic                 busy,
  output logic                 done,
  output logic                 sel_err,
  output logic [CNT_W-1:0]     trial_count,
  output logic [CNT_W-1:0]     err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_CHECK, S_DONE
  } state_t;

  // One extra bit so NUM_PATHS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NUM_PATHS_W = (SEL_W+1)'(NUM_PATHS);

  state_t              state;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    trials_q;
  logic [WAIT_W-1:0]   settle_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                cap_q;

  logic [NUM_PATHS-1:0] sel_mask;
  logic                 sel_bad;
  logic                 launch_level;
  logic                 path_obs;
  logic                 expected;
  logic [CNT_W-1:0]     trial_next;

  // Path selection is done with a one-hot mask so an out-of-range selector
  // can never index past the vector; sel_bad keeps it from running anyway.
  assign sel_mask     = NUM_PATHS'(1) << sel_q;
  assign sel_bad      = {1'b0, path_sel} >= NUM_PATHS_W;
  assign launch_level = |(path_in & sel_mask);
  assign path_obs     = |(path_out & sel_mask);
  assign expected     = launch_level ^ INVERT;
  assign trial_next   = trial_count + CNT_W'(1);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sel_q       <= '0;
      trials_q    <= '0;
      settle_q    <= '0;
      wait_cnt    <= '0;
      cap_q       <= 1'b0;
      path_in     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sel_err     <= 1'b0;
      trial_count <= '0;
      err_count   <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE && state != S_DONE) begin
        // Abort leaves counts and path_in at their partial values.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              sel_q       <= path_sel;
              trials_q    <= num_trials;
              settle_q    <= settle_cycles;
              trial_count <= '0;
              err_count   <= '0;
              sel_err     <= sel_bad;
              busy        <= 1'b1;
              if (sel_bad || num_trials == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_LAUNCH;
              end
            end
          end
          S_LAUNCH: begin
            path_in  <= path_in ^ sel_mask;
            wait_cnt <= settle_q;
            state    <= (settle_q == '0) ? S_CAPTURE : S_WAIT;
          end
          S_WAIT: begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
            if (wait_cnt == WAIT_W'(1)) state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            // Deliberately a single raw flop: metastability is the measurand.
            cap_q <= path_obs;
            state <= S_CHECK;
          end
          S_CHECK: begin
            trial_count <= trial_next;
            if (cap_q != expected && err_count != '1)
              err_count <= err_count + CNT_W'(1);
            if (trial_next == trials_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LAUNCH;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_path_sequencer.sv
// Directed bench for ro_path_sequencer: three instances (main 4-path,
// 3-path inverting, 4-bit counter) with behavioural path models.
module tb_ro_path_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_now  = 0;

  // main instance
  logic        m_start = 1'b0, m_abort = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [15:0] m_trials = '0;
  logic [3:0]  m_settle = '0;
  logic [3:0]  m_pin, m_pout;
  logic        m_busy, m_done, m_selerr;
  logic [15:0] m_tc, m_ec;
  int          path_mode = 0;
  logic [3:0]  d1 = '0, d2 = '0;

  always @(posedge clk) begin
    d1 <= m_pin;
    d2 <= d1;
  end

  always_comb begin
    m_pout = m_pin;
    case (path_mode)
      0:       m_pout = m_pin;
      1:       m_pout = d2;
      default: m_pout = ~m_pin;
    endcase
  end

  ro_path_sequencer #(.NUM_PATHS(4), .SEL_W(2), .CNT_W(16), .WAIT_W(4), .INVERT(1'b0)) u_main (
    .clk(clk), .rst(rst), .start(m_start), .abort(m_abort), .path_sel(m_sel),
    .num_trials(m_trials), .settle_cycles(m_settle), .path_in(m_pin), .path_out(m_pout),
    .busy(m_busy), .done(m_done), .sel_err(m_selerr), .trial_count(m_tc), .err_count(m_ec));

  // 3-path inverting instance
  logic        n_start = 1'b0, n_abort = 1'b0;
  logic [1:0]  n_sel = '0;
  logic [15:0] n_trials = '0;
  logic [3:0]  n_settle = '0;
  logic [2:0]  n_pin, n_pout;
  logic        n_busy, n_done, n_selerr;
  logic [15:0] n_tc, n_ec;
  assign n_pout = n_pin ^ 3'b111;

  ro_path_sequencer #(.NUM_PATHS(3), .SEL_W(2), .CNT_W(16), .WAIT_W(4), .INVERT(1'b1)) u_np3 (
    .clk(clk), .rst(rst), .start(n_start), .abort(n_abort), .path_sel(n_sel),
    .num_trials(n_trials), .settle_cycles(n_settle), .path_in(n_pin), .path_out(n_pout),
    .busy(n_busy), .done(n_done), .sel_err(n_selerr), .trial_count(n_tc), .err_count(n_ec));

  // 4-bit counter instance with a stuck-wrong path
  logic        s_start = 1'b0, s_abort = 1'b0;
  logic [1:0]  s_sel = '0;
  logic [3:0]  s_trials = '0;
  logic [3:0]  s_settle = '0;
  logic [3:0]  s_pin, s_pout;
  logic        s_busy, s_done, s_selerr;
  logic [3:0]  s_tc, s_ec;
  assign s_pout = ~s_pin;

  ro_path_sequencer #(.NUM_PATHS(4), .SEL_W(2), .CNT_W(4), .WAIT_W(4), .INVERT(1'b0)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .path_sel(s_sel),
    .num_trials(s_trials), .settle_cycles(s_settle), .path_in(s_pin), .path_out(s_pout),
    .busy(s_busy), .done(s_done), .sel_err(s_selerr), .trial_count(s_tc), .err_count(s_ec));

  function automatic logic get_done(input int w);
    case (w)
      0:       return m_done;
      1:       return n_done;
      default: return s_done;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return m_busy;
      1:       return n_busy;
      default: return s_busy;
    endcase
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_now++;
  endtask

  // Leaves the bench at the negedge of cycle 1 (start sampled at edge 0).
  task automatic start_only(input int w, input int sel, input int trials, input int settle);
    @(negedge clk);
    case (w)
      0: begin m_sel = 2'(sel); m_trials = 16'(trials); m_settle = 4'(settle); m_start = 1'b1; end
      1: begin n_sel = 2'(sel); n_trials = 16'(trials); n_settle = 4'(settle); n_start = 1'b1; end
      default: begin s_sel = 2'(sel); s_trials = 4'(trials); s_settle = 4'(settle); s_start = 1'b1; end
    endcase
    @(negedge clk);
    m_start = 1'b0; n_start = 1'b0; s_start = 1'b0;
    cyc_now = 1;
    check("busy_cycle1", longint'(get_busy(w)), 1);
  endtask

  task automatic wait_done(input int w, input int budget, output int cyc);
    cyc = -1;
    while (!get_done(w) && cyc_now < budget) tick();
    if (get_done(w)) cyc = cyc_now;
  endtask

  // Full run; returns at the negedge of the cycle after done (counts stable).
  task automatic run_to_done(input int w, input int sel, input int trials, input int settle,
                             input string tag, input int exp_cyc);
    int cyc;
    start_only(w, sel, trials, settle);
    wait_done(w, exp_cyc + 20, cyc);
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    tick();
    check({tag, "_done_pulse"}, longint'(get_done(w)), 0);
    check({tag, "_busy_fall"}, longint'(get_busy(w)), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_path_in", m_pin, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_sel_err", m_selerr, 0);
    check("rst_trial", m_tc, 0);
    check("rst_err", m_ec, 0);
    rst = 1'b0;

    // Ideal loopback, sel=1, N=5, settle=2: done in cycle 5*5+1
    path_mode = 0;
    run_to_done(0, 1, 5, 2, "loop", 26);
    check("loop_trial", m_tc, 5);
    check("loop_err", m_ec, 0);
    check("loop_path_in", m_pin, 4'b0010);

    // Two-stage delayed path, settle=1 too short, settle=2 sufficient
    path_mode = 1;
    run_to_done(0, 2, 4, 1, "dly1", 17);
    check("dly1_trial", m_tc, 4);
    check("dly1_err", m_ec, 4);
    run_to_done(0, 2, 4, 2, "dly2", 21);
    check("dly2_trial", m_tc, 4);
    check("dly2_err", m_ec, 0);
    check("dly2_path_in", m_pin, 4'b0010);

    // Zero trials
    path_mode = 0;
    run_to_done(0, 1, 0, 5, "zero", 1);
    check("zero_trial", m_tc, 0);
    check("zero_err", m_ec, 0);
    check("zero_path_in", m_pin, 4'b0010);

    // Start pulsed mid-run with different parameters is ignored
    start_only(0, 0, 3, 3);
    while (cyc_now < 5) tick();
    m_sel = 2'd3; m_trials = 16'd1; m_settle = 4'd0; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    wait_done(0, 40, cyc);
    check("ign_done_cycle", cyc, 19);
    check("ign_trial", m_tc, 3);
    check("ign_path_in", m_pin, 4'b0011);
    tick();

    // Abort in WAIT of trial 3 (sel=3, N=5, settle=4; trial 3 WAIT = cycles 16..19)
    start_only(0, 3, 5, 4);
    while (cyc_now < 17) tick();
    m_abort = 1'b1;
    tick();
    m_abort = 1'b0;
    check("abort_busy", m_busy, 0);
    check("abort_trial", m_tc, 2);
    check("abort_err", m_ec, 0);
    check("abort_path_in", m_pin, 4'b1011);
    seen = m_done;
    repeat (4) begin
      tick();
      seen = seen | m_done;
    end
    check("abort_no_done", seen, 0);

    // Reset during CHECK of trial 2 (sel=1, N=4, settle=0)
    start_only(0, 1, 4, 0);
    while (cyc_now < 6) tick();
    check("pre_rst_trial", m_tc, 1);
    rst = 1'b1;
    #1;
    check("midrst_path_in", m_pin, 0);
    check("midrst_busy", m_busy, 0);
    check("midrst_trial", m_tc, 0);
    @(negedge clk);
    rst = 1'b0;
    run_to_done(0, 1, 3, 0, "post_rst", 10);
    check("post_rst_trial", m_tc, 3);
    check("post_rst_err", m_ec, 0);
    check("post_rst_path_in", m_pin, 4'b0010);

    // NUM_PATHS=3: out-of-range select, then a normal inverting run
    run_to_done(1, 3, 2, 1, "selbad", 1);
    check("selbad_sel_err", n_selerr, 1);
    check("selbad_trial", n_tc, 0);
    check("selbad_path_in", n_pin, 0);
    run_to_done(1, 2, 3, 1, "np3", 13);
    check("np3_sel_err", n_selerr, 0);
    check("np3_trial", n_tc, 3);
    check("np3_err", n_ec, 0);
    check("np3_path_in", n_pin, 3'b100);

    // CNT_W=4 stuck-wrong path: every trial mismatches
    run_to_done(2, 0, 15, 0, "stuck", 46);
    check("stuck_trial", s_tc, 15);
    check("stuck_err", s_ec, 15);
    check("stuck_path_in", s_pin, 4'b0001);

    // Saturation: preload err_count to all-ones mid-run, 8 further mismatches
    start_only(2, 0, 10, 0);
    while (cyc_now < 7) tick();
    check("sat_pre_err", s_ec, 2);
    force u_sat.err_count = 4'hF;
    #1;
    release u_sat.err_count;
    wait_done(2, 50, cyc);
    check("sat_done_cycle", cyc, 31);
    check("sat_trial", s_tc, 10);
    check("sat_err", s_ec, 15);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_path_sequencer.md
# ro_path_sequencer

Measurement controller for the inverter-chain delay paths. It owns NUM_PATHS chain instances: it drives each chain's input and receives each chain's output. On command it repeatedly launches a transition into one selected chain and samples that chain's output a programmable number of clock cycles later. Each sample is compared with the expected settled level, and the block counts trials and mismatches so software can tell whether the path meets the given timing window.

## Interface
Parameters:
- NUM_PATHS, 4, number of delay-path instances driven/observed (≥1)
- SEL_W, 2, width of path_sel; must satisfy 2**SEL_W ≥ NUM_PATHS
- CNT_W, 16, width of num_trials, trial_count, err_count
- WAIT_W, 4, width of settle_cycles
- INVERT, 0, 1 when the chain has an odd inverter count (output = ~input when settled)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a measurement run (accepted only in IDLE)
- abort  in  1  terminate a run in progress
- path_sel  in  SEL_W  chain to measure, latched at start
- num_trials  in  CNT_W  trials per run, latched at start
- settle_cycles  in  WAIT_W  extra clock cycles between launch and capture, latched at start
- path_in  out  NUM_PATHS  registered drive to each chain input
- path_out  in  NUM_PATHS  chain outputs (asynchronous to launch by design)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal run completion
- sel_err  out  1  high when the latched path_sel ≥ NUM_PATHS; held until next accepted start
- trial_count  out  CNT_W  trials completed in current/last run
- err_count  out  CNT_W  mismatching trials in current/last run

## Operation
- States: IDLE, LAUNCH, WAIT, CAPTURE, CHECK, DONE.
- IDLE, start=1:
  - Latch sel, trials, settle.
  - Clear trial_count, err_count and sel_err.
  - If sel ≥ NUM_PATHS: set sel_err and go to DONE.
  - Else if trials=0: go to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle):
  - At its exiting edge E, path_in[sel] toggles and wait_cnt ← settle.
  - Next state is CAPTURE if settle=0, else WAIT.
- WAIT: wait_cnt decrements each cycle and the state lasts exactly settle cycles; go to CAPTURE when wait_cnt=1.
- CAPTURE (1 cycle): at its exiting edge, cap_q ← path_out[sel]. This is a single raw capture flop, no synchronizer; metastability is part of what is being measured. Capture edge = E + settle + 1.
- CHECK (1 cycle):
  - expected = path_in[sel] ^ INVERT.
  - If cap_q ≠ expected, err_count increments, saturating at all-ones.
  - trial_count increments.
  - If the new trial_count = trials, go to DONE; else go to LAUNCH.
- DONE (1 cycle): done=1, then go to IDLE.
- Unselected path_in bits hold their values throughout a run. path_in is never reset except by rst, so successive trials alternate rising and falling launches.
- start in any state other than IDLE is ignored.
- abort=1 in any busy state except DONE: go to IDLE next edge with no done pulse. Counts hold their partial values; path_in holds.
- When abort and start are both high in IDLE, start wins.

## Timing
- Reset values: state IDLE, path_in=0, busy=0, done=0, sel_err=0, trial_count=0, err_count=0, cap_q=0, wait_cnt=0.
- All outputs are registered.
- Per-trial cost is settle+3 cycles.
- With start sampled at edge 0, done is high during cycle N·(settle+3)+1.
- For trials=0 or sel_err, done is high during cycle 1.
- busy rises in the cycle after start is sampled and falls in the cycle after DONE.
- trial_count and err_count update at the CHECK exiting edge and are stable while done=1.
- rst asserted mid-run returns everything to reset values immediately, including path_in.

## Test plan
- Ideal loopback (path_out = path_in ^ INVERT, combinational), sel=1, N=5, settle=2 → done during cycle 26; trial_count=5, err_count=0; path_in[1] toggled 5 times (ends at 1); other bits stay 0.
- Path modelled as a 2-stage register delay, N=4: settle=1 → err_count=4; settle=2 → err_count=0; trial_count=4 in both cases.
- num_trials=0 → done during cycle 1, counts 0, path_in unchanged. Separately, NUM_PATHS=3 with sel=3 → sel_err=1 and done during cycle 1.
- Start during a run:
  - Pulse start while busy → ignored; latched parameters unchanged.
  - Pulse abort in the WAIT of trial 3 → IDLE next cycle, no done pulse, trial_count=2.
- Assert rst during CHECK of trial 2 → all outputs and path_in return to 0 at once. A new start then runs normally from trial 0.
- CNT_W=4, stuck-wrong path, N=15 → err_count=15. Confirm no wrap by forcing err_count to 15 and running one more mismatch → remains 15.
